// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder
//   Registered 68000 bus decoder driven by a runtime-loaded region table.
//   Each table entry holds base, mask, access mode and a wait-state count.
//   A bus cycle is decoded once per AS assertion. The lowest matching entry
//   wins and drives a one-hot chip select. DTACK follows after the entry's
//   wait count.
//
//   Optional feature macro: M68K_REGION_BERR_EN
//     defined   : an unmapped access held for TIMEOUT cycles raises berr_n=0
//                 until AS is released.
//     undefined : berr_n is tied high and an unmapped access waits for AS
//                 release indefinitely.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   cfg_we/cfg_idx          table write strobe and entry index
//   cfg_base/mask/wait/mode entry contents (mode 00 off, 01 rd, 10 wr, 11 rw)
//   m68k_a/as_n/rw          CPU address, address strobe, direction (1 = read)
//   cs                      one-hot registered chip selects
//   region_idx              index of the latched hit
//   hit                     current cycle decoded to a region
//   dtack_n, berr_n         bus handshake back to the CPU, active low

// One table entry: the configuration register plus its address/direction match.
module m68k_region_entry #(
  parameter int AW     = 24,
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     cfg_base,
  input  logic [AW-1:0]     cfg_mask,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic [1:0]        cfg_mode,
  input  logic [AW-1:0]     a,
  input  logic              rw,
  output logic              match,
  output logic [WAIT_W-1:0] wait_cnt
);

  logic [AW-1:0] base_q, mask_q;
  logic [1:0]    mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      mask_q   <= '0;
      wait_cnt <= '0;
      mode_q   <= 2'b00;
    end else if (we) begin
      base_q   <= cfg_base;
      mask_q   <= cfg_mask;
      wait_cnt <= cfg_wait;
      mode_q   <= cfg_mode;
    end
  end

  // mode bit 0 enables reads, bit 1 enables writes; 00 therefore never matches
  assign match = (rw ? mode_q[0] : mode_q[1]) && ((a & mask_q) == (base_q & mask_q));

endmodule

module m68k_region_decoder #(
  parameter int NUM_REGIONS = 16,
  parameter int AW          = 24,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 64,
  localparam int IW         = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_we,
  input  logic [IW-1:0]          cfg_idx,
  input  logic [AW-1:0]          cfg_base,
  input  logic [AW-1:0]          cfg_mask,
  input  logic [WAIT_W-1:0]      cfg_wait,
  input  logic [1:0]             cfg_mode,
  input  logic [AW-1:0]          m68k_a,
  input  logic                   m68k_as_n,
  input  logic                   m68k_rw,
  output logic [NUM_REGIONS-1:0] cs,
  output logic [IW-1:0]          region_idx,
  output logic                   hit,
  output logic                   dtack_n,
  output logic                   berr_n
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_MISS, S_BERR} state_t;

  state_t state, state_nxt;

  // input sampling: AS plus the address/direction captured on the same edge
  logic          as_q, rw_q;
  logic [AW-1:0] a_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      as_q <= 1'b1;
      rw_q <= 1'b1;
      a_q  <= '0;
    end else begin
      as_q <= m68k_as_n;
      rw_q <= m68k_rw;
      a_q  <= m68k_a;
    end
  end

  // region table
  logic [NUM_REGIONS-1:0]             match;
  logic [NUM_REGIONS-1:0][WAIT_W-1:0] wait_vec;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_entry
    // indices at or above NUM_REGIONS never equal any g, so they are dropped
    m68k_region_entry #(.AW(AW), .WAIT_W(WAIT_W)) u_entry (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (cfg_we && (32'(cfg_idx) == g)),
      .cfg_base (cfg_base),
      .cfg_mask (cfg_mask),
      .cfg_wait (cfg_wait),
      .cfg_mode (cfg_mode),
      .a        (a_q),
      .rw       (rw_q),
      .match    (match[g]),
      .wait_cnt (wait_vec[g])
    );
  end

  // priority select: scanning downward lets the lowest matching index win
  logic                   dec_hit;
  logic [IW-1:0]          dec_idx;
  logic [WAIT_W-1:0]      dec_wait;
  logic [NUM_REGIONS-1:0] dec_cs;

  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_wait = '0;
    dec_cs   = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        dec_hit   = 1'b1;
        dec_idx   = IW'(i);
        dec_wait  = wait_vec[i];
        dec_cs    = '0;
        dec_cs[i] = 1'b1;
      end
    end
  end

  // bus-cycle FSM
  logic [WAIT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_REGIONS-1:0] cs_nxt;
  logic [IW-1:0]          idx_nxt;
  logic                   hit_nxt;

`ifdef M68K_REGION_BERR_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cs_nxt    = cs;
    idx_nxt   = region_idx;
    hit_nxt   = hit;
`ifdef M68K_REGION_BERR_EN
    tcnt_nxt  = tcnt;
`endif
    case (state)
      S_IDLE: begin
        if (!as_q) begin
          if (dec_hit) begin
            cs_nxt  = dec_cs;
            idx_nxt = dec_idx;
            hit_nxt = 1'b1;
            if (dec_wait == '0) begin
              state_nxt = S_ACK;
            end else begin
              state_nxt = S_WAIT;
              cnt_nxt   = dec_wait;
            end
          end else begin
            state_nxt = S_MISS;
`ifdef M68K_REGION_BERR_EN
            tcnt_nxt  = TW'(TIMEOUT);
`endif
          end
        end
      end
      // counter holds the edges still to go; ACK is entered when it reads 1,
      // which puts DTACK exactly W edges after the chip select
      S_WAIT: begin
        if (as_q) begin
          state_nxt = S_IDLE;
        end else if (cnt == WAIT_W'(1)) begin
          state_nxt = S_ACK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - WAIT_W'(1);
        end
      end
      S_ACK: begin
        if (as_q) state_nxt = S_IDLE;
      end
      S_MISS: begin
        if (as_q) begin
          state_nxt = S_IDLE;
        end
`ifdef M68K_REGION_BERR_EN
        else if (tcnt <= TW'(1)) begin
          state_nxt = S_BERR;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt - TW'(1);
        end
`endif
      end
      S_BERR: begin
        if (as_q) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // every return to IDLE (release, abort) drops the latched decode
    if (state_nxt == S_IDLE) begin
      cs_nxt  = '0;
      idx_nxt = '0;
      hit_nxt = 1'b0;
      cnt_nxt = '0;
    end
  end

  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cs         <= '0;
      region_idx <= '0;
      hit        <= 1'b0;
      dtack_n    <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cs         <= cs_nxt;
      region_idx <= idx_nxt;
      hit        <= hit_nxt;
      dtack_n    <= (state_nxt != S_ACK);
    end
  end

`ifdef M68K_REGION_BERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt   <= '0;
      berr_n <= 1'b1;
    end else begin
      tcnt   <= tcnt_nxt;
      berr_n <= (state_nxt != S_BERR);
    end
  end
`else
  assign berr_n = 1'b1;
`endif

endmodule
